ifmap_wadr_gen: RTL and testbench

Write-side address generator for the double-buffered ifmap SRAM. It is the counterpart of the ifmap read address generator.
- Accepts a stream of ifmap words from the upstream deserializer over a valid/ready handshake.
- Produces sequential write addresses covering one IX0 x IY0 x IC1 tile, channel-major.
- Toggles the write bank after each tile and stalls when both banks hold unconsumed tiles, until the reader releases one.

---
 rtl/ifmap_wadr_gen_if.sv | 41 ++++
 rtl/ifmap_wadr_gen.sv | 198 +++++++++++++++++++
 tb/tb_ifmap_wadr_gen.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ifmap_wadr_gen_if.sv
// Bus bundle for the ifmap write address generator.
// Holds the config load, the upstream valid/ready word stream, the SRAM write strobe/address/bank
// and the reader release. clk and rst_n are not part of the bundle.
// The macro IFMAP_WADR_ERR_EN adds the sticky err flag.
// Handshake: a word transfers on a cycle where in_valid and in_ready are both high. That cycle
// is also the SRAM write cycle, so wen == in_valid & in_ready. in_ready is never a function of in_valid.
interface ifmap_wadr_gen_if #(
    parameter int BANK_ADDR_WIDTH = 8
);
    logic                           config_en;
    logic [3*BANK_ADDR_WIDTH-1:0]   config_data;
    logic                           in_valid;
    logic                           in_ready;
    logic                           wen;
    logic [BANK_ADDR_WIDTH-1:0]     adr;
    logic                           wbank;
    logic                           tile_done;
    logic                           rd_release;
    logic [1:0]                     dbg_state;
`ifdef IFMAP_WADR_ERR_EN
    logic                           err;

    modport master (
        output config_en, config_data, in_valid, rd_release,
        input  in_ready, wen, adr, wbank, tile_done, dbg_state, err
    );
    modport slave (
        input  config_en, config_data, in_valid, rd_release,
        output in_ready, wen, adr, wbank, tile_done, dbg_state, err
    );
`else
    modport master (
        output config_en, config_data, in_valid, rd_release,
        input  in_ready, wen, adr, wbank, tile_done, dbg_state
    );
    modport slave (
        input  config_en, config_data, in_valid, rd_release,
        output in_ready, wen, adr, wbank, tile_done, dbg_state
    );
`endif
endinterface

// File: rtl/ifmap_wadr_gen.sv
// Write-side address generator for the double-buffered ifmap SRAM.
// It writes one IX0 x IY0 x IC1 tile, channel-major, into the current bank, then toggles the bank.
// It stalls when both banks hold tiles that the reader has not yet released.
// Optional macro IFMAP_WADR_ERR_EN adds a sticky err output. err is set by a release underflow
// or by a stall that lasts longer than 2^BANK_ADDR_WIDTH cycles.
module ifmap_wadr_gen #(
    parameter int BANK_ADDR_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    ifmap_wadr_gen_if.slave    bus
);
    localparam int W = BANK_ADDR_WIDTH;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    localparam logic [1:0] S_UNCFG = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] ix0_q, ix0_d, iy0_q, iy0_d, ic1_q, ic1_d;
    logic [W-1:0] x_q, x_d, y_q, y_d, c_q, c_d;
    logic [W-1:0] adr_q, adr_d;
    logic         wbank_q, wbank_d;
    logic [1:0]   occ_q, occ_d;
    logic         tile_done_q, tile_done_d;

    logic [W-1:0] cfg_ix0, cfg_iy0, cfg_ic1;
    logic         in_ready_c, wen_c, last_c, tile_end_c, rel_ok_c;

    assign cfg_ix0 = bus.config_data[3*W-1:2*W];
    assign cfg_iy0 = bus.config_data[2*W-1:W];
    assign cfg_ic1 = bus.config_data[W-1:0];

    // Ready comes from registered state only; the config cycle blocks any transfer.
    assign in_ready_c = (state_q == S_FILL) && !bus.config_en;
    assign wen_c      = bus.in_valid && in_ready_c;
    assign last_c     = (x_q == ix0_q - ONE) && (y_q == iy0_q - ONE) && (c_q == ic1_q - ONE);
    assign tile_end_c = wen_c && last_c;
    // A release only counts when the reader actually holds a tile.
    assign rel_ok_c   = bus.rd_release && (occ_q != 2'd0);

    // Next-state logic: config load, tile counters, bank toggle and occupancy tracking.
    always_comb begin
        state_d     = state_q;
        ix0_d       = ix0_q;
        iy0_d       = iy0_q;
        ic1_d       = ic1_q;
        x_d         = x_q;
        y_d         = y_q;
        c_d         = c_q;
        adr_d       = adr_q;
        wbank_d     = wbank_q;
        occ_d       = occ_q;
        tile_done_d = 1'b0;

        if (bus.config_en) begin
            ix0_d   = cfg_ix0;
            iy0_d   = cfg_iy0;
            ic1_d   = cfg_ic1;
            x_d     = '0;
            y_d     = '0;
            c_d     = '0;
            adr_d   = '0;
            wbank_d = 1'b0;
            occ_d   = 2'd0;
            state_d = ((cfg_ix0 != '0) && (cfg_iy0 != '0) && (cfg_ic1 != '0)) ? S_FILL : S_UNCFG;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (wen_c) begin
                        if (last_c) begin
                            x_d         = '0;
                            y_d         = '0;
                            c_d         = '0;
                            adr_d       = '0;
                            wbank_d     = ~wbank_q;
                            tile_done_d = 1'b1;
                        end else begin
                            adr_d = adr_q + ONE;
                            if (x_q == ix0_q - ONE) begin
                                x_d = '0;
                                if (y_q == iy0_q - ONE) begin
                                    y_d = '0;
                                    c_d = c_q + ONE;
                                end else begin
                                    y_d = y_q + ONE;
                                end
                            end else begin
                                x_d = x_q + ONE;
                            end
                        end
                    end
                    // A tile finishing together with a release leaves occupancy unchanged.
                    if (tile_end_c && bus.rd_release) begin
                        occ_d = occ_q;
                    end else if (tile_end_c) begin
                        occ_d = occ_q + 2'd1;
                    end else if (rel_ok_c) begin
                        occ_d = occ_q - 2'd1;
                    end
                    if (occ_d == 2'd2) begin
                        state_d = S_FULL;
                    end
                end
                S_FULL: begin
                    if (rel_ok_c) begin
                        occ_d   = occ_q - 2'd1;
                        state_d = S_FILL;
                    end
                end
                default: begin
                    state_d = S_UNCFG;
                end
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_UNCFG;
            ix0_q       <= '0;
            iy0_q       <= '0;
            ic1_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            c_q         <= '0;
            adr_q       <= '0;
            wbank_q     <= 1'b0;
            occ_q       <= 2'd0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ix0_q       <= ix0_d;
            iy0_q       <= iy0_d;
            ic1_q       <= ic1_d;
            x_q         <= x_d;
            y_q         <= y_d;
            c_q         <= c_d;
            adr_q       <= adr_d;
            wbank_q     <= wbank_d;
            occ_q       <= occ_d;
            tile_done_q <= tile_done_d;
        end
    end

`ifdef IFMAP_WADR_ERR_EN
    // The stall counter saturates at 2^W. One more stalled cycle after that trips the watchdog.
    localparam logic [W:0] STALL_MAX = {1'b1, {W{1'b0}}};

    logic         err_q, err_d;
    logic [W:0]   stall_q, stall_d;

    // Sticky error: release underflow or an over-long upstream stall; config clears it.
    always_comb begin
        err_d   = err_q;
        stall_d = stall_q;
        if (bus.config_en) begin
            err_d   = 1'b0;
            stall_d = '0;
        end else begin
            if (bus.rd_release && (occ_q == 2'd0) && !tile_end_c) begin
                err_d = 1'b1;
            end
            if (bus.in_valid && !in_ready_c) begin
                if (stall_q == STALL_MAX) begin
                    err_d = 1'b1;
                end else begin
                    stall_d = stall_q + {{W{1'b0}}, 1'b1};
                end
            end else begin
                stall_d = '0;
            end
        end
    end

    // Error flag and watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    assign bus.err = err_q;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.wen       = wen_c;
    assign bus.adr       = adr_q;
    assign bus.wbank     = wbank_q;
    assign bus.tile_done = tile_done_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_ifmap_wadr_gen.sv
// Directed testbench for ifmap_wadr_gen.
// Inputs change 1 ns after the rising edge. Outputs are checked 5 ns after the edge.
module tb_ifmap_wadr_gen;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ifmap_wadr_gen_if #(.BANK_ADDR_WIDTH(W)) bus ();

    ifmap_wadr_gen #(.BANK_ADDR_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    // One config cycle: ready must be low and no write may happen during it.
    task automatic cfg(input logic [W-1:0] ix, input logic [W-1:0] iy, input logic [W-1:0] ic);
        bus.config_en   = 1'b1;
        bus.config_data = {ix, iy, ic};
        settle();
        chk("cfg_ready_low", 32'(bus.in_ready), 32'd0);
        chk("cfg_no_wen", 32'(bus.wen), 32'd0);
        tick();
        bus.config_en = 1'b0;
    endtask

    initial begin
        int e;
        rst_n           = 1'b0;
        bus.config_en   = 1'b0;
        bus.config_data = '0;
        bus.in_valid    = 1'b1;
        bus.rd_release  = 1'b0;

        // Reset values while reset is held, with in_valid high
        tick();
        tick();
        settle();
        chk("rst_adr", 32'(bus.adr), 32'd0);
        chk("rst_wbank", 32'(bus.wbank), 32'd0);
        chk("rst_tile_done", 32'(bus.tile_done), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_wen", 32'(bus.wen), 32'd0);
        tick();
        rst_n = 1'b1;
        settle();
        chk("uncfg_ready", 32'(bus.in_ready), 32'd0);
        tick();

        // A config with a zero field keeps the block unconfigured
        cfg(8'd5, 8'd0, 8'd2);
        settle();
        chk("zero_field_uncfg", 32'(bus.in_ready), 32'd0);
        tick();

        // Tile 1: 5x5x2, in_valid held high, addresses 0..49 back to back
        cfg(8'd5, 8'd5, 8'd2);
        for (int i = 0; i < 50; i++) begin
            settle();
            chk("t1_wen", 32'(bus.wen), 32'd1);
            chk("t1_adr", 32'(bus.adr), 32'(i));
            tick();
        end
        bus.in_valid = 1'b0;
        settle();
        chk("t1_tile_done", 32'(bus.tile_done), 32'd1);
        chk("t1_wbank", 32'(bus.wbank), 32'd1);
        chk("t1_adr_wrap", 32'(bus.adr), 32'd0);
        chk("t1_ready", 32'(bus.in_ready), 32'd1);
        tick();

        // Tile 2: in_valid toggles, addresses stay gap-free
        e = 0;
        for (int k = 0; k < 100; k++) begin
            bus.in_valid = (k % 2 == 1);
            settle();
            if (k == 0) chk("t1_done_one_pulse", 32'(bus.tile_done), 32'd0);
            chk("t2_wen", 32'(bus.wen), 32'(bus.in_valid));
            chk("t2_adr", 32'(bus.adr), 32'(e));
            if (bus.in_valid) e++;
            tick();
        end

        // Both banks are now occupied, so the block must stall
        bus.in_valid = 1'b1;
        settle();
        chk("t2_tile_done", 32'(bus.tile_done), 32'd1);
        chk("full_wbank", 32'(bus.wbank), 32'd0);
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        chk("full_wen", 32'(bus.wen), 32'd0);
        chk("full_adr", 32'(bus.adr), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_wen", 32'(bus.wen), 32'd0);
            tick();
        end
        bus.rd_release = 1'b1;
        settle();
        chk("release_cycle_ready", 32'(bus.in_ready), 32'd0);
        tick();
        bus.rd_release = 1'b0;

        // Tile 3: its last word coincides with rd_release
        for (int i = 0; i < 50; i++) begin
            bus.rd_release = (i == 49);
            settle();
            if (i == 0) chk("ready_after_release", 32'(bus.in_ready), 32'd1);
            chk("t3_adr", 32'(bus.adr), 32'(i));
            chk("t3_wen", 32'(bus.wen), 32'd1);
            tick();
        end
        bus.rd_release = 1'b0;
        settle();
        chk("t3_tile_done", 32'(bus.tile_done), 32'd1);
        chk("t3_no_stall", 32'(bus.in_ready), 32'd1);
        chk("t3_wbank", 32'(bus.wbank), 32'd1);
        chk("t4_adr0", 32'(bus.adr), 32'd0);
        tick();

        // Tile 4 runs to adr 17, then a new config arrives mid-tile
        for (int i = 1; i < 17; i++) begin
            settle();
            chk("t4_adr", 32'(bus.adr), 32'(i));
            tick();
        end
        bus.config_en   = 1'b1;
        bus.config_data = {8'd3, 8'd3, 8'd1};
        settle();
        chk("midcfg_adr", 32'(bus.adr), 32'd17);
        chk("midcfg_ready", 32'(bus.in_ready), 32'd0);
        chk("midcfg_wen", 32'(bus.wen), 32'd0);
        tick();
        bus.config_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            settle();
            if (i == 0) chk("midcfg_wbank", 32'(bus.wbank), 32'd0);
            chk("small_adr", 32'(bus.adr), 32'(i));
            chk("small_wen", 32'(bus.wen), 32'd1);
            tick();
        end
        settle();
        chk("small_tile_done", 32'(bus.tile_done), 32'd1);
        chk("small_wbank", 32'(bus.wbank), 32'd1);
        chk("small_adr_wrap", 32'(bus.adr), 32'd0);
        tick();
        for (int i = 1; i < 3; i++) begin
            settle();
            chk("pre_rst_adr", 32'(bus.adr), 32'(i));
            tick();
        end

        // Asynchronous reset in the middle of a tile
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_adr", 32'(bus.adr), 32'd0);
        chk("arst_wbank", 32'(bus.wbank), 32'd0);
        chk("arst_ready", 32'(bus.in_ready), 32'd0);
        chk("arst_wen", 32'(bus.wen), 32'd0);
        chk("arst_tile_done", 32'(bus.tile_done), 32'd0);
        #2;
        tick();
        rst_n = 1'b1;
        settle();
        chk("uncfg_after_reset", 32'(bus.in_ready), 32'd0);
        tick();

`ifdef IFMAP_WADR_ERR_EN
        // A release at zero occupancy raises a sticky err
        bus.rd_release = 1'b1;
        settle();
        chk("err_before", 32'(bus.err), 32'd0);
        tick();
        bus.rd_release = 1'b0;
        settle();
        chk("err_set", 32'(bus.err), 32'd1);
        tick();
        settle();
        chk("err_held", 32'(bus.err), 32'd1);
        tick();
`endif

        // A release at zero occupancy is ignored; two small tiles then fill both banks
        cfg(8'd3, 8'd3, 8'd1);
        bus.in_valid   = 1'b0;
        bus.rd_release = 1'b1;
        settle();
        chk("underflow_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.rd_release = 1'b0;
        bus.in_valid   = 1'b1;
        for (int i = 0; i < 18; i++) begin
            settle();
            chk("two_small_adr", 32'(bus.adr), 32'(i % 9));
            tick();
        end
        settle();
        chk("two_small_full", 32'(bus.in_ready), 32'd0);
        chk("two_small_done", 32'(bus.tile_done), 32'd1);
        chk("two_small_wbank", 32'(bus.wbank), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
